// File: rtl/dmem_mmio.sv
// Data-memory stage behind the core's MEM stage: 64-bit word RAM plus an MMIO window
// (TXDATA / STATUS / CYCLE). Loads are combinational and stores commit on the clock edge.
// A TX FIFO drains through tx_valid/tx_ready; a push that finds the FIFO full is dropped
// and sets sticky overflow. Optional macro DMEM_CYCLE_COUNTER_EN adds the CYCLE counter.
//
// Ports:
//   clk, reset                - clock; synchronous active-low reset
//   addr, writeData, memWrite - byte address, right-aligned store data, store strobe
//   memType                   - funct3 access type (lb/lh/lw/ld/lbu/lhu/lwu, 111 reserved)
//   readData, misaligned      - combinational load result and alignment flag
//   tx_data, tx_valid         - TX FIFO head byte and non-empty flag
//   tx_ready                  - sink accepts the head byte
module dmem_mmio #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter int unsigned TX_DEPTH  = 16,
  parameter logic [63:0] MMIO_BASE = 64'h0000_0000_1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] addr,
  input  logic [63:0] writeData,
  input  logic        memWrite,
  input  logic [2:0]  memType,
  output logic [63:0] readData,
  output logic        misaligned,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam logic [TAW:0] PTR_ONE = 1;
  localparam logic [TAW:0] DEPTH_C = TX_DEPTH[TAW:0];

  // ---------------- access decode ----------------
  logic           is_ram;
  logic [63:0]    mmio_off;
  logic           acc_ok;
  logic           mmio_ok;
  logic [RAW-1:0] ram_idx;

  always_comb begin
    misaligned = 1'b0;
    case (memType)
      3'b001, 3'b101: misaligned = addr[0];
      3'b010, 3'b110: misaligned = |addr[1:0];
      3'b011:         misaligned = |addr[2:0];
      default:        misaligned = 1'b0;
    endcase
  end

  assign is_ram   = addr < MMIO_BASE;
  assign mmio_off = addr - MMIO_BASE;
  assign acc_ok   = (memType != 3'b111) && !misaligned;
  // MMIO registers are 64-bit only; narrower types act like a reserved access.
  assign mmio_ok  = acc_ok && (memType == 3'b011);
  assign ram_idx  = addr[RAW+2:3];

  // ---------------- RAM ----------------
  logic [63:0] ram_q [RAM_WORDS];
  logic [63:0] ram_sh;
  logic [63:0] ram_ext;
  logic [63:0] wdat_sh;
  logic [7:0]  wmask;
  logic        ram_we;

  assign ram_we  = memWrite && is_ram && acc_ok;
  assign ram_sh  = ram_q[ram_idx] >> {addr[2:0], 3'b000};
  assign wdat_sh = writeData << {addr[2:0], 3'b000};

  always_comb begin
    case (memType[1:0])
      2'b00:   wmask = 8'h01;
      2'b01:   wmask = 8'h03;
      2'b10:   wmask = 8'h0F;
      default: wmask = 8'hFF;
    endcase
    wmask = wmask << addr[2:0];
  end

  always_comb begin
    case (memType)
      3'b000:  ram_ext = {{56{ram_sh[7]}},  ram_sh[7:0]};
      3'b001:  ram_ext = {{48{ram_sh[15]}}, ram_sh[15:0]};
      3'b010:  ram_ext = {{32{ram_sh[31]}}, ram_sh[31:0]};
      3'b011:  ram_ext = ram_sh;
      3'b100:  ram_ext = {56'b0, ram_sh[7:0]};
      3'b101:  ram_ext = {48'b0, ram_sh[15:0]};
      3'b110:  ram_ext = {32'b0, ram_sh[31:0]};
      default: ram_ext = '0;
    endcase
  end

  // RAM contents survive reset; only the write is blocked during the reset cycle.
  always_ff @(posedge clk) begin
    if (reset && ram_we) begin
      for (int b = 0; b < 8; b++) begin
        if (wmask[b]) ram_q[ram_idx][b*8 +: 8] <= wdat_sh[b*8 +: 8];
      end
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]   fifo_q [TX_DEPTH];
  logic [TAW:0] rd_ptr_q, rd_ptr_d;
  logic [TAW:0] wr_ptr_q, wr_ptr_d;
  logic [TAW:0] count_q, count_d;
  logic         ovf_q, ovf_d;
  logic         tx_push, push_acc, push_drop, pop, clr_wr, fifo_full;

  assign tx_valid  = count_q != '0;
  assign tx_data   = fifo_q[rd_ptr_q[TAW-1:0]];
  assign fifo_full = count_q == DEPTH_C;
  assign pop       = tx_valid && tx_ready;
  assign tx_push   = memWrite && !is_ram && mmio_ok && (mmio_off == 64'h0);
  assign clr_wr    = memWrite && !is_ram && mmio_ok && (mmio_off == 64'h8) && writeData[2];
  // A full FIFO still takes a byte if the head leaves in the same cycle.
  assign push_acc  = tx_push && (!fifo_full || pop);
  assign push_drop = tx_push && !push_acc;

  always_comb begin
    rd_ptr_d = pop      ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    wr_ptr_d = push_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    count_d  = count_q;
    if (push_acc && !pop)      count_d = count_q + PTR_ONE;
    else if (!push_acc && pop) count_d = count_q - PTR_ONE;
    // Setting overflow takes priority over a clear in the same cycle.
    ovf_d = ovf_q;
    if (push_drop)   ovf_d = 1'b1;
    else if (clr_wr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push_acc) fifo_q[wr_ptr_q[TAW-1:0]] <= writeData[7:0];
  end

  // ---------------- CYCLE counter ----------------
  logic [63:0] cycle_rd;
`ifdef DMEM_CYCLE_COUNTER_EN
  logic [63:0] cycle_q, cycle_d;
  assign cycle_d  = cycle_q + 64'd1;
  assign cycle_rd = cycle_q;
  always_ff @(posedge clk) begin
    if (!reset) cycle_q <= '0;
    else        cycle_q <= cycle_d;
  end
`else
  assign cycle_rd = '0;
`endif

  // ---------------- read mux ----------------
  logic [63:0] status;
  logic [63:0] mmio_rd;

  assign status = {48'b0, 8'(count_q), 5'b0, ovf_q, ~tx_valid, fifo_full};

  always_comb begin
    case (mmio_off)
      64'h08:  mmio_rd = status;
      64'h10:  mmio_rd = cycle_rd;
      default: mmio_rd = '0;
    endcase
  end

  always_comb begin
    readData = '0;
    if (acc_ok) begin
      if (is_ram)       readData = ram_ext;
      else if (mmio_ok) readData = mmio_rd;
    end
  end

endmodule
